// File: rtl/conv_pkg.sv
// Shared constants and packing helpers for the conv core and its feeders.
package conv_pkg;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_IN_CHANNELS = 9;
   localparam int KERNEL_TAPS     = 9;

   // Flat bit offset of (tap, channel) inside a packed 3x3 window.
   function automatic int tap_offset(
      input int tap,
      input int ch,
      input int nch,
      input int dw
   );
      return (tap * nch + ch) * dw;
   endfunction

endpackage

// File: rtl/conv_window_feeder_if.sv
// Valid/ready stream bundle used for the pixel input and window output.
interface conv_window_feeder_if #(
   parameter int W = 8
);

   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/conv_line_buffer.sv
// One image line of pixel storage: single write port, async read at same index.
module conv_line_buffer #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 72
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream to packed 3x3xC valid-only windows for the conv core.
// CONV_WINDOW_FEEDER_POS_EN adds win_x/win_y output-map coordinates.
module conv_window_feeder
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int IN_CHANNELS = DEF_IN_CHANNELS,
   parameter int IMG_W       = 64,
   parameter int IMG_H       = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   conv_window_feeder_if.slave  pix,
   conv_window_feeder_if.master win,
   output logic                 frame_done
`ifdef CONV_WINDOW_FEEDER_POS_EN
   ,
   output logic [$clog2(IMG_W)-1:0] win_x,
   output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

   localparam int PW = IN_CHANNELS * DATA_WIDTH;
   localparam int WW = KERNEL_TAPS * PW;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          win_valid_q;
   logic [WW-1:0] win_pixels_q;
   logic [WW-1:0] win_next;
   logic [PW-1:0] lb0_rd;
   logic [PW-1:0] lb1_rd;
   logic [PW-1:0] nc [3];
   logic [PW-1:0] cr [2][3];
   logic          accept;
   logic          emit;
   logic          last_col;
   logic          last_px;

   assign pix.ready  = !win_valid_q || win.ready;
   assign accept     = pix.valid && pix.ready;
   assign last_col   = (col == CW'(IMG_W - 1));
   assign last_px    = last_col && (row == RW'(IMG_H - 1));
   assign emit       = accept && (row >= RW'(2)) && (col >= CW'(2));
   assign win.valid  = win_valid_q;
   assign win.data   = win_pixels_q;

   conv_line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (PW)
   ) lb0 (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (pix.data),
      .rdata (lb0_rd)
   );

   conv_line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (PW)
   ) lb1 (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (lb0_rd),
      .rdata (lb1_rd)
   );

   // New column is oldest line on top; window = two held columns + new one.
   always_comb begin
      nc[0]    = lb1_rd;
      nc[1]    = lb0_rd;
      nc[2]    = pix.data;
      win_next = '0;
      for (int dr = 0; dr < 3; dr++) begin
         win_next[tap_offset(dr*3, 0, IN_CHANNELS, DATA_WIDTH) +: PW] =
            cr[0][dr];
         win_next[tap_offset(dr*3+1, 0, IN_CHANNELS, DATA_WIDTH) +: PW] =
            cr[1][dr];
         win_next[tap_offset(dr*3+2, 0, IN_CHANNELS, DATA_WIDTH) +: PW] =
            nc[dr];
      end
   end

   // Column history needs no reset: the row/col gate masks stale taps.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int dr = 0; dr < 3; dr++) begin
            cr[0][dr] <= cr[1][dr];
            cr[1][dr] <= nc[dr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col          <= '0;
         row          <= '0;
         win_valid_q  <= 1'b0;
         win_pixels_q <= '0;
         frame_done   <= 1'b0;
`ifdef CONV_WINDOW_FEEDER_POS_EN
         win_x        <= '0;
         win_y        <= '0;
`endif
      end else begin
         frame_done <= accept && last_px;
         if (accept) begin
            if (last_col) begin
               col <= '0;
               row <= last_px ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         if (emit) begin
            win_valid_q  <= 1'b1;
            win_pixels_q <= win_next;
`ifdef CONV_WINDOW_FEEDER_POS_EN
            win_x        <= col - CW'(2);
            win_y        <= row - RW'(2);
`endif
         end else if (win.ready) begin
            win_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Randomized/directed bench for conv_window_feeder with a frame-image model.
module tb_conv_window_feeder;

   localparam int DW = 8;
   localparam int IC = 3;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = IC * DW;
   localparam int WW = 9 * PW;

   logic clk = 1'b0;
   logic reset;
   logic frame_done;
`ifdef CONV_WINDOW_FEEDER_POS_EN
   logic [1:0] win_x;
   logic [1:0] win_y;
`endif

   conv_window_feeder_if #(.W(PW)) pix_if ();
   conv_window_feeder_if #(.W(WW)) win_if ();

   conv_window_feeder #(
      .DATA_WIDTH  (DW),
      .IN_CHANNELS (IC),
      .IMG_W       (W),
      .IMG_H       (H)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pix        (pix_if),
      .win        (win_if),
      .frame_done (frame_done)
`ifdef CONV_WINDOW_FEEDER_POS_EN
      ,
      .win_x      (win_x),
      .win_y      (win_y)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model state
   logic [PW-1:0] img [H][W];
   int            mr, mc;
   logic [WW-1:0] exp_q [$];
   int            expx_q [$];
   int            expy_q [$];
   bit            exp_wv, exp_fd, hold_chk;
   logic [WW-1:0] held;

   // observed windows per phase
   logic [WW-1:0] got_q [$];
   int            gotx_q [$];
   int            goty_q [$];
   int            fd_cnt;
   int            stall_seen;

   task automatic chk(input string n, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", n, act, req);
      end
   endtask

   task automatic chkw(input string n, input logic [WW-1:0] act,
                       input logic [WW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", n, act, req);
      end
   endtask

   function automatic int tapv(input logic [WW-1:0] w, input int j,
                               input int k);
      return int'(w[(j*IC+k)*DW +: DW]);
   endfunction

   task automatic check_win(input string n, input logic [WW-1:0] w,
                            input int base, input int e [9]);
      for (int j = 0; j < 9; j++) chk(n, tapv(w, j, 0), base + e[j]);
   endtask

   // compare process: one pass per cycle, away from the active edge
   always @(negedge clk) begin
      logic          acc, wacc, emit;
      logic [WW-1:0] ew;
      if (reset) begin
         mr = 0; mc = 0;
         exp_q.delete(); expx_q.delete(); expy_q.delete();
         exp_wv = 0; exp_fd = 0; hold_chk = 0;
      end else begin
         acc  = pix_if.valid && pix_if.ready;
         wacc = win_if.valid && win_if.ready;
         chk("in_ready", int'(pix_if.ready),
             int'(!win_if.valid || win_if.ready));
         chk("win_valid", int'(win_if.valid), int'(exp_wv));
         chk("frame_done", int'(frame_done), int'(exp_fd));
         if (frame_done) fd_cnt++;
         if (win_if.valid && !win_if.ready) stall_seen++;
         if (hold_chk && win_if.valid) chkw("hold", win_if.data, held);
         if (wacc) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL extra_window: got %h expected none",
                        win_if.data);
            end else begin
               ew = exp_q.pop_front();
               chkw("window", win_if.data, ew);
               got_q.push_back(win_if.data);
`ifdef CONV_WINDOW_FEEDER_POS_EN
               chk("win_x", int'(win_x), expx_q.pop_front());
               chk("win_y", int'(win_y), expy_q.pop_front());
               gotx_q.push_back(int'(win_x));
               goty_q.push_back(int'(win_y));
`endif
            end
         end
         hold_chk = win_if.valid && !win_if.ready;
         held     = win_if.data;
         exp_fd   = 0;
         emit     = 0;
         if (acc) begin
            img[mr][mc] = pix_if.data;
            if (mr >= 2 && mc >= 2) begin
               ew = '0;
               for (int dr = 0; dr < 3; dr++)
                  for (int dc = 0; dc < 3; dc++)
                     ew[(dr*3+dc)*PW +: PW] = img[mr-2+dr][mc-2+dc];
               exp_q.push_back(ew);
               expx_q.push_back(mc - 2);
               expy_q.push_back(mr - 2);
               emit = 1;
            end
            if (mr == H-1 && mc == W-1) exp_fd = 1;
            mc++;
            if (mc == W) begin
               mc = 0;
               mr = (mr == H-1) ? 0 : mr + 1;
            end
         end
         exp_wv = emit || (win_if.valid && !win_if.ready);
      end
   end

   // mode 0: steady, 1: stall first window 3 cycles, 2: random 50%
   task automatic send(input int base, input int mode, input int npix);
      int idx = 0, guard = 0, stalls = 0;
      logic took;
      while (idx < npix && guard < 2000) begin
         pix_if.valid = (mode == 2) ? 1'($urandom % 2) : 1'b1;
         for (int k = 0; k < IC; k++)
            pix_if.data[k*DW +: DW] = DW'(16*k + base + idx);
         win_if.ready = (mode == 2) ? 1'($urandom % 2) : 1'b1;
         if (mode == 1 && stalls < 3 && win_if.valid) begin
            win_if.ready = 1'b0;
            stalls++;
         end
         @(negedge clk);
         took = pix_if.valid && pix_if.ready;
         @(posedge clk);
         #1;
         if (took) idx++;
         guard++;
      end
      chk("send_timeout", int'(guard >= 2000), 0);
   endtask

   task automatic drain();
      pix_if.valid = 1'b0;
      win_if.ready = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      chk("drained", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      pix_if.valid = 1'b0;
      win_if.ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic new_phase();
      got_q.delete(); gotx_q.delete(); goty_q.delete();
      fd_cnt = 0; stall_seen = 0;
   endtask

   int first_w [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
   int last_w  [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

   initial begin
      int viol;
      reset        = 1'b1;
      pix_if.valid = 1'b0;
      pix_if.data  = '0;
      win_if.ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_win_valid", int'(win_if.valid), 0);
      chk("rst_win_pixels", int'(win_if.data == '0), 1);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_in_ready", int'(pix_if.ready), 1);
      @(posedge clk);
      #1;

      new_phase();
      send(0, 0, 16);
      drain();
      chk("a_count", got_q.size(), 4);
      chk("a_frame_done", fd_cnt, 1);
      if (got_q.size() >= 4) begin
         check_win("a_first", got_q[0], 0, first_w);
         check_win("a_last", got_q[3], 0, last_w);
         chk("a_tap8_ch2", tapv(got_q[0], 8, 2), 42);
         chk("a_tap0_ch1", tapv(got_q[3], 0, 1), 21);
      end

      new_phase();
      send(0, 1, 16);
      drain();
      chk("b_count", got_q.size(), 4);
      chk("b_stall_cycles", stall_seen, 3);
      if (got_q.size() >= 1) check_win("b_first", got_q[0], 0, first_w);

      new_phase();
      send(0, 0, 16);
      send(100, 0, 16);
      drain();
      chk("c_count", got_q.size(), 8);
      chk("c_frame_done", fd_cnt, 2);
      if (got_q.size() >= 8) begin
         check_win("c_f2_first", got_q[4], 100, first_w);
         viol = 0;
         for (int i = 4; i < 8; i++)
            for (int j = 0; j < 9; j++)
               if (tapv(got_q[i], j, 0) < 100) viol++;
         chk("c_f2_stale", viol, 0);
      end

      new_phase();
      send(0, 0, 10);
      do_reset();
      new_phase();
      send(50, 0, 16);
      drain();
      chk("d_count", got_q.size(), 4);
      if (got_q.size() >= 4) begin
         check_win("d_first", got_q[0], 50, first_w);
         check_win("d_last", got_q[3], 50, last_w);
      end

      new_phase();
      send(30, 2, 16);
      drain();
      chk("e_count", got_q.size(), 4);
`ifdef CONV_WINDOW_FEEDER_POS_EN
      if (gotx_q.size() >= 4) begin
         chk("e_x0", gotx_q[0], 0); chk("e_y0", goty_q[0], 0);
         chk("e_x1", gotx_q[1], 1); chk("e_y1", goty_q[1], 0);
         chk("e_x2", gotx_q[2], 0); chk("e_y2", goty_q[2], 1);
         chk("e_x3", gotx_q[3], 1); chk("e_y3", goty_q[3], 1);
      end
`endif
      if (got_q.size() >= 4) check_win("e_last", got_q[3], 30, last_w);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Producer side of the conv core's window interface: accepts a raster-order stream of multi-channel pixels and emits 3x3xIN_CHANNELS windows packed in the layout the conv core consumes.
- Sits between the frame/pixel source and the convolution core.
- Uses two line buffers plus a 3-column shift window.
- Valid-only convolution: no padding, so one window per pixel at row≥2, col≥2, giving (IMG_W-2)*(IMG_H-2) windows per frame.

Parameters:
- DATA_WIDTH, 8, bits per channel sample.
- IN_CHANNELS, 9, channels per pixel.
- IMG_W, 64, pixels per line (≥3).
- IMG_H, 64, lines per frame (≥3).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  feeder can accept a pixel.
- in_pixel  in  IN_CHANNELS*DATA_WIDTH  one pixel; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- win_valid  out  1  window valid.
- win_ready  in  1  consumer accepts the window.
- win_pixels  out  9*IN_CHANNELS*DATA_WIDTH  window; tap j (0..8, j=row*3+col, j=0 top-left/oldest, j=8 bottom-right/newest), channel k at bits [(j*IN_CHANNELS+k)*DATA_WIDTH +: DATA_WIDTH].
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (synchronous, active-high):
  - win_valid=0, win_pixels=0, frame_done=0.
  - Column counter and row counter return to 0.
  - Line-buffer contents are not cleared; stale data is masked by the row counter.
- Input accept: in_ready = !win_valid || win_ready, so it is combinational and reset drops it only via win_valid. A pixel is accepted when in_valid && in_ready.
- On accept at (row r, col c):
  - Read the column {lb1[c], lb0[c], in_pixel} (oldest to newest line).
  - Write lb1[c]<=lb0[c] and lb0[c]<=in_pixel.
  - Shift the 3x3 column register left and insert the new column at col index 2.
  - c increments. At c=IMG_W-1, c wraps to 0 and r increments. At r=IMG_H-1 together with c=IMG_W-1, r also wraps to 0 and frame_done pulses on the next cycle.
- Window emit: when the accepted pixel has r≥2 and c≥2, win_valid<=1 on the next cycle, with win_pixels holding the updated column register. Latency from accept to window is 1 cycle.
- Hold: while win_valid && !win_ready, win_pixels and win_valid are held stable and in_ready=0.
- Window clear: when win_valid && win_ready and no new emitting accept occurs in the same cycle, win_valid<=0. A simultaneous accept and emit gives back-to-back windows at 1 per cycle.
- Column register across line wrap: holds columns from the previous line at c=0,1. These are never emitted because of the c≥2 gate.
- Frame boundaries: back-to-back frames need no gap. The first two lines of each new frame emit nothing, and line-buffer data from the previous frame is masked by r<2.
- Pacing: in_valid low creates bubbles. Counters advance only on accept, so the block is fully elastic.
- Reset mid-frame: the in-flight window is dropped, counters restart, and the next accepted pixel is treated as (0,0).
- Arithmetic: no computation on pixel values, only bit-exact transport. Counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide.

Optional Feature:
- Macro: CONV_WINDOW_FEEDER_POS_EN.
- Defined: adds outputs win_x [$clog2(IMG_W)-1:0] and win_y [$clog2(IMG_H)-1:0], giving the output-map coordinate (c-2, r-2) of the current window.
  - Registered alongside win_pixels and held under backpressure.
  - Reset value 0.
- Undefined: these ports and their registers are absent. All other behaviour is identical.

Decomposition:
- Shared package conv_pkg holds:
  - DATA_WIDTH/IN_CHANNELS defaults.
  - The KERNEL_TAPS=9 constant.
  - A function computing the flat bit offset of (tap, channel), shared with the conv core wrappers and benches.
- One sub-module: conv_line_buffer.
  - IMG_W x (IN_CHANNELS*DATA_WIDTH) storage, single write port with asynchronous read at the same index.
  - Instantiated twice (lb0, lb1).

Test Plan:
- W=4, H=4, DATA_WIDTH=8, IN_CHANNELS=1, pixel=r*4+c, win_ready=1, continuous valid -> exactly 4 windows:
  - First window {0,1,2,4,5,6,8,9,10}, last window {5,6,7,9,10,11,13,14,15}.
  - frame_done pulses once, 1 cycle after pixel 15 is accepted.
- Same stimulus with win_ready low for 3 cycles on the first window -> win_pixels stable and in_ready=0 for those cycles; no window lost or duplicated; totals unchanged.
- IN_CHANNELS=3, channel k = 16*k + pixel index -> each tap's channel ordering matches the offset function for all 4 windows.
- Two frames back-to-back with different contents (second frame = pixel+100) -> 8 windows total; no window in frame 2 contains frame-1 data; first frame-2 window {100,101,102,104,105,106,108,109,110}.
- Reset asserted after pixel 9 of frame 1, then a full frame sent -> exactly 4 correct windows, none from pre-reset data.
- With CONV_WINDOW_FEEDER_POS_EN and random in_valid/win_ready at 50% -> (win_x, win_y) sequence is (0,0),(1,0),(0,1),(1,1) paired with the correct windows.
